// File: rtl/micromind_pkg.sv
// Shared definitions for micromind and its consumer-side change logger.
package micromind_pkg;

  localparam int VALUE_W  = 8;
  localparam int TS_W_DEF = 16;

  typedef struct packed {
    logic [VALUE_W-1:0]  value;
    logic [TS_W_DEF-1:0] stamp;
  } rec_t;

endpackage

// File: rtl/value_monitor_if.sv
// Show-ahead read port of the value change log: head record plus valid/ready.
interface value_monitor_if #(
  parameter int TS_W = micromind_pkg::TS_W_DEF
);
  import micromind_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [VALUE_W-1:0] out_value;
  logic [TS_W-1:0]    out_stamp;

  modport master (output out_valid, output out_value, output out_stamp, input out_ready);
  modport slave  (input out_valid, input out_value, input out_stamp, output out_ready);

endinterface

// File: rtl/value_fifo.sv
// Synchronous FIFO with show-ahead head, occupancy count, and push-when-full
// accepted only if a pop frees the slot on the same edge.
module value_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_full;
  logic          w_pop;

  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign o_valid   = (r_level != '0);
  assign w_pop     = o_valid && i_ready;
  assign o_push_ok = i_push && (!w_full || w_pop);
  assign o_dout    = r_mem[r_rptr];
  assign o_level   = r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (o_push_ok) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (o_push_ok && !w_pop)      r_level <= r_level + 1'b1;
      else if (!o_push_ok && w_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/value_monitor.sv
// Logs every change of micromind's value output with a cycle timestamp.
// Define VALUE_MONITOR_FILTER_EN to require two equal consecutive samples.
module value_monitor
  import micromind_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VALUE_W-1:0]     value_in,
  value_monitor_if.master        rd,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int REC_W = VALUE_W + TS_W;

  logic [TS_W-1:0]    r_cyc;
  logic               r_first;
  logic [VALUE_W-1:0] r_last;
  logic [VALUE_W-1:0] r_val_p1;
  logic [TS_W-1:0]    r_ts_p1;
  logic               r_overflow;
  logic               w_det;
  logic               w_push;
  logic               w_push_ok;
  logic [REC_W-1:0]   w_rec;
  logic [REC_W-1:0]   w_head;

  always_ff @(posedge clk) begin
    if (reset) r_cyc <= '0;
    else       r_cyc <= r_cyc + 1'b1;
  end

  // Stage 1: sample value and timestamp every edge
  always_ff @(posedge clk) begin
    r_val_p1 <= value_in;
    r_ts_p1  <= r_cyc;
  end

`ifdef VALUE_MONITOR_FILTER_EN
  logic               r_vld_p1;
  logic               r_chg_p2;
  logic [VALUE_W-1:0] r_val_p2;
  logic [TS_W-1:0]    r_ts_p2;

  // A value counts only once the current input matches the previous sample.
  assign w_det = r_vld_p1 && (value_in == r_val_p1) && (r_first || (value_in != r_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_first  <= 1'b1;
      r_last   <= '0;
      r_chg_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b1;
      r_chg_p2 <= w_det;
      if (w_det) begin
        r_first <= 1'b0;
        r_last  <= value_in;
      end
    end
  end

  // Stage 2: confirmed record, stamped with its first sample
  always_ff @(posedge clk) begin
    r_val_p2 <= r_val_p1;
    r_ts_p2  <= r_ts_p1;
  end

  assign w_push = r_chg_p2;
  assign w_rec  = {r_val_p2, r_ts_p2};
`else
  logic r_chg_p1;

  assign w_det = r_first || (value_in != r_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_first  <= 1'b1;
      r_last   <= '0;
      r_chg_p1 <= 1'b0;
    end else begin
      r_first  <= 1'b0;
      r_last   <= value_in;
      r_chg_p1 <= w_det;
    end
  end

  assign w_push = r_chg_p1;
  assign w_rec  = {r_val_p1, r_ts_p1};
`endif

  // Push stage: store the record or flag its loss
  value_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_din     (w_rec),
    .i_ready   (rd.out_ready),
    .o_valid   (rd.out_valid),
    .o_dout    (w_head),
    .o_level   (level),
    .o_push_ok (w_push_ok)
  );

  always_ff @(posedge clk) begin
    if (reset)                      r_overflow <= 1'b0;
    else if (w_push && !w_push_ok)  r_overflow <= 1'b1;
  end

  assign overflow     = r_overflow;
  assign rd.out_value = w_head[REC_W-1:TS_W];
  assign rd.out_stamp = w_head[TS_W-1:0];

endmodule

// File: tb/tb_value_monitor.sv
// Scoreboard bench for value_monitor: a per-edge reference model feeds an
// expected-record queue that a negedge monitor checks against the read port.
`timescale 1ns/1ps
module tb_value_monitor;
  import micromind_pkg::*;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef VALUE_MONITOR_FILTER_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 1;
`endif

  typedef struct {
    logic [7:0]      v;
    logic [TS_W-1:0] ts;
  } erec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    value_in = 8'h00;
  logic [LW-1:0] level;
  logic          overflow;

  value_monitor_if #(.TS_W(TS_W)) rd ();

  value_monitor #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .rd       (rd),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  bit    started = 0;
  erec_t exp_q[$];

  int          m_lvl;
  bit          m_ovf;
  int unsigned m_n;
  bit          m_first;
  logic [7:0]  m_last;
  bit          m_prev_vld;
  logic [7:0]  m_prev_v;
  bit          m_pend;
  erec_t       m_pend_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what gets logged is decided from the sample history alone;
  // a record is offered to the log one edge after it is recognised.
  initial begin : model
    bit    pop;
    bit    det;
    erec_t r;
    forever begin
      @(posedge clk);
      if (reset) begin
        started    = 1;
        m_lvl      = 0;
        m_ovf      = 0;
        m_n        = 0;
        m_first    = 1;
        m_last     = 8'h00;
        m_prev_vld = 0;
        m_pend     = 0;
        exp_q.delete();
      end else begin
        pop = (m_lvl != 0) && rd.out_ready;
        if (m_pend) begin
          if (m_lvl < DEPTH || pop) begin
            exp_q.push_back(m_pend_r);
            m_lvl++;
          end else begin
            m_ovf = 1;
          end
        end
        if (pop) m_lvl--;
`ifdef VALUE_MONITOR_FILTER_EN
        det  = m_prev_vld && (value_in == m_prev_v) && (m_first || value_in != m_last);
        r.v  = value_in;
        r.ts = TS_W'(m_n - 1);
        if (det) begin
          m_first = 0;
          m_last  = value_in;
        end
        m_prev_vld = 1;
        m_prev_v   = value_in;
`else
        det     = m_first || (value_in != m_last);
        r.v     = value_in;
        r.ts    = TS_W'(m_n);
        m_first = 0;
        m_last  = value_in;
`endif
        m_pend   = det;
        m_pend_r = r;
        m_n++;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (started) begin
        chk("level", 32'(level), m_lvl);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_valid", 32'(rd.out_valid), 32'(m_lvl != 0));
        if (rd.out_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_record: got value %0h stamp %0h, required none", rd.out_value, rd.out_stamp);
          end else begin
            chk("out_value", 32'(rd.out_value), 32'(exp_q[0].v));
            chk("out_stamp", 32'(rd.out_stamp), 32'(exp_q[0].ts));
            if (rd.out_ready && !reset) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic [7:0] v, input int n);
    value_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    rd.out_ready = 1'b1;
    reset        = 1'b1;
    value_in     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_value", 32'(rd.out_value), 32'h0);
    chk("rst_out_stamp", 32'(rd.out_stamp), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    reset = 1'b0;
    step(8'h00, 6);

    // First change latency, then consecutive steps
    value_in = 8'h01;
    for (int e = 1; e <= HOLD + 1; e++) begin
      @(posedge clk);
      #1;
      chk("latency_valid", 32'(rd.out_valid), 32'(e == HOLD + 1));
    end
    step(8'h02, HOLD);
    step(8'h03, HOLD);
    step(8'h03, 4);

    // Overflow: consumer stalled, ten distinct changes
    rd.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step(8'h20 + 8'(i), HOLD);
    step(8'h29, 3);
    chk("full_level", 32'(level), DEPTH);
    chk("full_overflow", 32'(overflow), 32'h1);
    rd.out_ready = 1'b1;
    step(8'h29, 12);

    // Full FIFO: pop and push on the same edge loses nothing
    reset = 1'b1;
    step(8'h40, 1);
    reset = 1'b0;
    step(8'h40, HOLD + 3);
    rd.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) step(8'h50 + 8'(i), HOLD);
    step(8'h57, 3);
    chk("fill_level", 32'(level), DEPTH);
    step(8'h60, HOLD);
    rd.out_ready = 1'b1;
    step(8'h60, 1);
    chk("pushpop_level", 32'(level), DEPTH);
    chk("pushpop_overflow", 32'(overflow), 32'h0);
    step(8'h60, 12);

    // Reset with five stored records and overflow set
    rd.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step(8'h70 + 8'(i), HOLD);
    step(8'h79, 3);
    rd.out_ready = 1'b1;
    step(8'h79, 3);
    rd.out_ready = 1'b0;
    step(8'h79, 1);
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_overflow", 32'(overflow), 32'h1);
    reset = 1'b1;
    step(8'h79, 1);
    chk("mid_rst_valid", 32'(rd.out_valid), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    step(8'h99, HOLD + 1);
    chk("post_rst_value", 32'(rd.out_value), 32'h99);
    chk("post_rst_stamp", 32'(rd.out_stamp), 32'h0);
    rd.out_ready = 1'b1;
    step(8'h99, 3);

    // Glitches around a steady level
    step(8'h10, 4);
    step(8'h55, 1);
    step(8'h10, 4);
    step(8'h55, 2);
    step(8'h10, 4);

    // Randomised traffic with stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0) value_in = 8'($urandom_range(0, 3));
      rd.out_ready = ($urandom_range(0, 3) != 0) && !(i % 100 >= 40 && i % 100 < 55);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    rd.out_ready = 1'b1;
    step(value_in, 30);
    chk("drained_level", 32'(level), 32'h0);
    chk("drained_valid", 32'(rd.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/value_monitor.md
# value_monitor

Consumer-side counterpart to `micromind`: samples its 8-bit `value` output every clock, detects changes, tags each new value with a cycle timestamp, and buffers the records in a small FIFO drained through a valid/ready read port. Instantiated next to `micromind` in the same clock domain. Gives the bench, and later a host-facing transmitter, a lossless change log instead of a per-cycle monitor.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_W`, 16, timestamp width in bits
- `clk` in 1: single clock; all logic is rising-edge
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`
- `value_in` in 8: the `micromind` `value` output
- `out_valid` out 1: head record available
- `out_ready` in 1: consumer accepts the head record
- `out_value` out 8: head record value
- `out_stamp` out TS_W: head record timestamp
- `level` out $clog2(DEPTH)+1: number of records stored
- `overflow` out 1: sticky; at least one record dropped

## Operation
- Cycle counter `cyc`, TS_W bits: 0 in the first cycle after reset, +1 every non-reset edge, wraps 2^TS_W−1 → 0 with no flag.
- Stage 1, sample: each edge registers `value_in` into `s_val` and `cyc` into `s_ts`. It also raises `s_chg` when `value_in` differs from `last`, or when the `first` flag is set.
- `first` is set by reset and cleared by the first sample. The first post-reset value is therefore always logged, even if it is 0.
- `last` updates to every sampled `value_in`, whether or not the record is stored.
- Stage 2, push: if `s_chg` and the FIFO is not full, or is full but popping this cycle, write {`s_val`, `s_ts`} at the write pointer. Otherwise, if `s_chg`, drop the record and set `overflow`.
- `overflow` clears only on reset.
- Read side: `out_valid` = level ≠ 0. `out_value`/`out_stamp` show the head entry directly from registers, with no read latency.
- Pop on edge with `out_valid && out_ready`.
- `out_value`/`out_stamp` stay stable while `out_valid && !out_ready`.
- `out_ready` while empty has no effect.
- Simultaneous push and pop: `level` unchanged. When full, the push is accepted because the pop frees the slot.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` counts 0..DEPTH.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0; `out_value`=0, `out_stamp`=0 (storage cleared)
  - `cyc`=0, `first`=1, `last`=0, `s_chg`=0
- Reset asserted mid-operation discards all stored records, pending stage-1 state and `overflow` on that edge.
- Latency: `value_in` changes before edge k. It is sampled at edge k with stamp = `cyc` before that edge's increment. It is written at edge k+1, so `out_valid` rises after edge k+1 when the FIFO was empty: 2 edges.
- Throughput: one record per cycle in, one per cycle out.
- Back-to-back changes every cycle are each logged.

## Configuration
- `VALUE_MONITOR_FILTER_EN` defined: adds a glitch filter. A new value is logged only after it has been sampled on two consecutive edges.
  - The stamp is that of the first of the two samples.
  - Latency becomes 3 edges.
  - A single-cycle pulse is ignored and does not update `last`.
  - The first post-reset value also needs two equal samples.
- Undefined: no filter; behaviour exactly as in Operation.

## Structure
- Shared package `micromind_pkg`:
  - `VALUE_W` = 8
  - default `TS_W`
  - record typedef {value, stamp}
- One sub-module: `value_fifo`, a synchronous FIFO with show-ahead head, `level`, and push-when-full-with-pop rule. `value_monitor` holds the counter, change detection, filter and overflow.

## Test plan
- Reset for 2 cycles, `value_in`=0x00 steady, `out_ready`=1. Expect exactly one record {0x00, stamp 0}, then `out_valid`=0 thereafter.
- `value_in` steps 0x01,0x02,0x03 on consecutive cycles with `out_ready`=1. Expect three records with stamps n, n+1, n+2, and `out_valid` 2 edges after the first change.
- `out_ready`=0, 10 distinct changes, `DEPTH`=8:
  - expect `level` 8 and `overflow`=1
  - drained records are the first 8 values in order
- FIFO full plus `out_ready`=1 plus a new change on the same edge. Expect `level` to stay 8 and `overflow` to stay 0.
- `TS_W`=4, changes around cycle 15/16. Expect stamps 0xF then 0x0, with no error.
- Reset asserted with 5 records stored and `overflow`=1. Expect `out_valid`=0, `level`=0, `overflow`=0 after the edge. The first post-reset value is logged with stamp 0.
- With `VALUE_MONITOR_FILTER_EN`, a 1-cycle 0x55 glitch between steady 0x10 values produces no record, and a 2-cycle 0x55 produces one record.
